// File: rtl/mult4_sched.sv
// mult4_sched: round-robin front end sharing one sequential 4x4 multiplier
// (init/done protocol) among N_REQ requesters, with a done-wait watchdog.
module mult4_sched #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned INIT_LEN = 2,
  parameter int unsigned TIMEOUT  = 63
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [4*N_REQ-1:0]   req_a,
  input  logic [4*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [7:0]           rsp_pp,
  output logic                 rsp_err,
  output logic                 mult_init,
  output logic [3:0]           mult_a,
  output logic [3:0]           mult_b,
  input  logic [7:0]           mult_pp,
  input  logic                 mult_done,
  output logic                 busy,
  output logic [2:0]           grant_id
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned PW = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  logic [2:0]      last;
  logic [PW-1:0]   phase;
  logic [TW-1:0]   tcnt;
  logic [TW-1:0]   tcnt_nxt;
  logic            done_q;

  logic            found;
  logic [2:0]      win;
  logic [3:0]      win_a;
  logic [3:0]      win_b;

  function automatic logic [N_REQ-1:0] onehot(input logic [2:0] i);
    return {{(N_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  // Round-robin search beginning just after the last winner, wrapping at N_REQ-1.
  always_comb begin
    logic [3:0]       idx;
    logic [N_REQ-1:0] rv_sh;
    logic [4*N_REQ-1:0] sh_a;
    logic [4*N_REQ-1:0] sh_b;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    rv_sh = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = {1'b0, last} + 4'(k);
      if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
      rv_sh = req_valid >> idx;
      if (!found && rv_sh[0]) begin
        found = 1'b1;
        win   = idx[2:0];
      end
    end
    sh_a  = req_a >> (4 * win);
    sh_b  = req_b >> (4 * win);
    win_a = sh_a[3:0];
    win_b = sh_b[3:0];
  end

  // Saturating watchdog increment.
  always_comb begin
    tcnt_nxt = (tcnt == '1) ? tcnt : tcnt + 1'b1;
  end

  // Scheduler FSM; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      last      <= 3'(N_REQ - 1);
      phase     <= '0;
      tcnt      <= '0;
      done_q    <= 1'b0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_pp    <= '0;
      rsp_err   <= 1'b0;
      mult_init <= 1'b0;
      mult_a    <= '0;
      mult_b    <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            mult_a    <= win_a;
            mult_b    <= win_b;
            grant_id  <= win;
            last      <= win;
            phase     <= PW'(INIT_LEN - 1);
            req_ready <= onehot(win);
            mult_init <= 1'b1;
            busy      <= 1'b1;
            state     <= S_INIT;
          end
        end
        S_INIT: begin
          req_ready <= '0;
          if (phase == '0) begin
            mult_init <= 1'b0;
            tcnt      <= '0;
            // Pretend done was already high so a stale level cannot complete.
            done_q    <= 1'b1;
            state     <= S_WAIT;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        S_WAIT: begin
          done_q <= mult_done;
          if (mult_done && !done_q) begin
            rsp_pp    <= mult_pp;
            rsp_err   <= 1'b0;
            rsp_valid <= onehot(grant_id);
            state     <= S_RESP;
          end else if (tcnt_nxt == TW'(TIMEOUT)) begin
            rsp_pp    <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= onehot(grant_id);
            state     <= S_RESP;
          end else begin
            tcnt <= tcnt_nxt;
          end
        end
        S_RESP: begin
          rsp_valid <= '0;
          rsp_err   <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult4_sched.sv
// Directed bench for mult4_sched with a behavioural 10-cycle multiplier.
module tb_mult4_sched;

  localparam int N  = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_a, req_b;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [7:0]     rsp_pp;
  logic           rsp_err, mult_init, busy, mult_done;
  logic [3:0]     mult_a, mult_b;
  logic [7:0]     mult_pp;
  logic [2:0]     grant_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult4_sched #(.N_REQ(4), .INIT_LEN(2), .TIMEOUT(63)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_pp(rsp_pp), .rsp_err(rsp_err),
    .mult_init(mult_init), .mult_a(mult_a), .mult_b(mult_b), .mult_pp(mult_pp),
    .mult_done(mult_done), .busy(busy), .grant_id(grant_id)
  );

  // Behavioural multiplier: done rises 10 edges after init drops, stays high until next init.
  int         m_cnt;
  logic       m_done;
  logic [7:0] m_pp;
  logic       done_stuck = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_done <= 1'b0; m_pp <= '0;
    end else if (mult_init) begin
      m_cnt <= 10; m_done <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_pp   <= {4'b0, mult_a} * {4'b0, mult_b};
      end
    end
  end
  assign mult_done = done_stuck ? 1'b1 : m_done;
  assign mult_pp   = done_stuck ? 8'hAA : m_pp;

  // Observations gathered by run_op
  int         o_rdy_cnt, o_rdy_c, o_rdy_id, o_init_cnt, o_wait_c, o_rsp_c, o_gid_bad;
  logic [N-1:0] o_rsp_vec, o_rsp_after;
  logic [7:0] o_pp;
  logic       o_err, o_busy_after;

  // Issue one request from requester r starting in an IDLE cycle; record what happens.
  task automatic run_op(input int r, input logic [3:0] a, input logic [3:0] b,
                        input int wr, input int won, input int woff);
    int c;
    bit fin;
    o_rdy_cnt = 0; o_rdy_c = -1; o_rdy_id = -1; o_init_cnt = 0; o_wait_c = -1;
    o_rsp_c = -1; o_gid_bad = 0; o_rsp_vec = '0; o_pp = '0; o_err = 1'b0;
    o_busy_after = 1'b1; o_rsp_after = '1;
    req_a[4*r +: 4] = a;
    req_b[4*r +: 4] = b;
    req_valid[r] = 1'b1;
    c = 0; fin = 0;
    while (!fin && c < 200) begin
      @(negedge clk);
      c++;
      if (req_ready != '0) begin
        o_rdy_cnt += $countones(req_ready);
        if (o_rdy_c < 0) begin
          o_rdy_c = c;
          for (int i = 0; i < N; i++) if (req_ready[i]) o_rdy_id = i;
        end
      end
      if (req_ready[r]) req_valid[r] = 1'b0;
      if (mult_init) o_init_cnt++;
      if (o_wait_c < 0 && o_init_cnt > 0 && busy && !mult_init) o_wait_c = c;
      if (busy && grant_id != 3'(r)) o_gid_bad++;
      if (wr >= 0 && c == won)  req_valid[wr] = 1'b1;
      if (wr >= 0 && c == woff) req_valid[wr] = 1'b0;
      if (rsp_valid != '0) begin
        o_rsp_c = c; o_rsp_vec = rsp_valid; o_pp = rsp_pp; o_err = rsp_err; fin = 1;
      end
    end
    req_valid[r] = 1'b0;
    @(negedge clk);
    o_busy_after = busy;
    o_rsp_after  = rsp_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    #1;
    checks++; if ({req_ready, rsp_valid, rsp_pp, rsp_err, mult_init, mult_a, mult_b, busy, grant_id} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs busy=%0b grant=%0d", busy, grant_id); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || req_ready !== '0) begin
      errors++; $display("FAIL reset_idle: got busy=%0b ready=%b expected 0/0000", busy, req_ready); end
  endtask

  task automatic test_basic;
    run_op(0, 4'd3, 4'd3, -1, 0, 0);
    checks++; if (o_rdy_cnt !== 1 || o_rdy_c !== 1 || o_rdy_id !== 0) begin
      errors++; $display("FAIL basic_ready: got cnt=%0d cyc=%0d id=%0d expected 1/1/0", o_rdy_cnt, o_rdy_c, o_rdy_id); end
    checks++; if (o_init_cnt !== 2) begin
      errors++; $display("FAIL basic_init_len: got %0d expected 2", o_init_cnt); end
    checks++; if (o_wait_c !== 3) begin
      errors++; $display("FAIL basic_wait_entry: got %0d expected 3", o_wait_c); end
    checks++; if (o_rsp_c !== 14) begin
      errors++; $display("FAIL basic_latency: got cycle %0d expected 14", o_rsp_c); end
    checks++; if (o_rsp_vec !== 4'b0001 || o_pp !== 8'd9 || o_err !== 1'b0) begin
      errors++; $display("FAIL basic_rsp: got vec=%b pp=%0d err=%0b expected 0001/9/0", o_rsp_vec, o_pp, o_err); end
    checks++; if (o_rsp_after !== '0 || o_busy_after !== 1'b0) begin
      errors++; $display("FAIL basic_after: got rsp=%b busy=%0b expected 0000/0", o_rsp_after, o_busy_after); end
  endtask

  task automatic test_req2_max;
    run_op(2, 4'd15, 4'd15, -1, 0, 0);
    checks++; if (o_rdy_id !== 2) begin
      errors++; $display("FAIL r2_ready_id: got %0d expected 2", o_rdy_id); end
    checks++; if (o_rsp_vec !== 4'b0100 || o_pp !== 8'hE1 || o_err !== 1'b0) begin
      errors++; $display("FAIL r2_rsp: got vec=%b pp=%0h err=%0b expected 0100/e1/0", o_rsp_vec, o_pp, o_err); end
    checks++; if (o_gid_bad !== 0) begin
      errors++; $display("FAIL r2_grant_id: got %0d busy cycles with grant_id!=2 expected 0", o_gid_bad); end
  endtask

  task automatic test_timeout;
    done_stuck = 1'b1;
    run_op(1, 4'd5, 4'd5, -1, 0, 0);
    done_stuck = 1'b0;
    checks++; if (o_wait_c !== 3) begin
      errors++; $display("FAIL to_wait_entry: got %0d expected 3", o_wait_c); end
    checks++; if (o_rsp_c !== 66) begin
      errors++; $display("FAIL to_cycle: got rsp cycle %0d expected 66 (63 after WAIT entry)", o_rsp_c); end
    checks++; if (o_rsp_vec !== 4'b0010 || o_pp !== 8'd0 || o_err !== 1'b1) begin
      errors++; $display("FAIL to_rsp: got vec=%b pp=%0d err=%0b expected 0010/0/1", o_rsp_vec, o_pp, o_err); end
    checks++; if (o_busy_after !== 1'b0) begin
      errors++; $display("FAIL to_after: got busy=%0b expected 0", o_busy_after); end
  endtask

  task automatic test_reset_mid_wait;
    req_a[11:8] = 4'd9; req_b[11:8] = 4'd9;
    req_valid[2] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (req_ready[2]) req_valid[2] = 1'b0;
    end
    checks++; if (busy !== 1'b1 || mult_init !== 1'b0) begin
      errors++; $display("FAIL rst_pre_wait: got busy=%0b init=%0b expected 1/0", busy, mult_init); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({req_ready, rsp_valid, rsp_pp, rsp_err, mult_init, mult_a, mult_b, busy, grant_id} !== '0) begin
      errors++; $display("FAIL rst_async: got busy=%0b a=%0d b=%0d grant=%0d expected all 0", busy, mult_a, mult_b, grant_id); end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid[2] = 1'b1;
    run_op(0, 4'd6, 4'd7, -1, 0, 0);
    req_valid = '0;
    checks++; if (o_rdy_id !== 0) begin
      errors++; $display("FAIL rst_first_winner: got %0d expected 0", o_rdy_id); end
    checks++; if (o_rsp_vec !== 4'b0001 || o_pp !== 8'd42 || o_err !== 1'b0) begin
      errors++; $display("FAIL rst_rsp: got vec=%b pp=%0d err=%0b expected 0001/42/0", o_rsp_vec, o_pp, o_err); end
    @(negedge clk);
  endtask

  task automatic test_withdraw;
    run_op(3, 4'd2, 4'd5, 1, 5, 9);
    checks++; if (o_rdy_cnt !== 1 || o_rdy_id !== 3) begin
      errors++; $display("FAIL wd_ready: got cnt=%0d id=%0d expected 1/3", o_rdy_cnt, o_rdy_id); end
    checks++; if (o_rsp_vec !== 4'b1000 || o_pp !== 8'd10) begin
      errors++; $display("FAIL wd_rsp: got vec=%b pp=%0d expected 1000/10", o_rsp_vec, o_pp); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0 || req_ready !== '0) begin
        errors++; $display("FAIL wd_no_grant: got busy=%0b ready=%b expected 0/0000", busy, req_ready); end
    end
  endtask

  task automatic test_back_to_back;
    int exp_id[5] = '{0, 1, 2, 3, 0};
    int exp_pp[5] = '{2, 12, 30, 56, 2};
    int rdy_ord[6];
    int rsp_ord[6];
    int rsp_val[6];
    int nrdy, nrsp, c, not_onehot, rdy_since, multi;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_a = {4'd7, 4'd5, 4'd3, 4'd1};
    req_b = {4'd8, 4'd6, 4'd4, 4'd2};
    req_valid = '1;
    nrdy = 0; nrsp = 0; c = 0; not_onehot = 0; rdy_since = 0; multi = 0;
    for (int i = 0; i < 6; i++) begin rdy_ord[i] = -1; rsp_ord[i] = -1; rsp_val[i] = -1; end
    while (nrsp < 5 && c < 400) begin
      @(negedge clk);
      c++;
      if (req_ready != '0) begin
        if (!$onehot(req_ready)) not_onehot++;
        if (nrdy < 6) for (int i = 0; i < N; i++) if (req_ready[i]) rdy_ord[nrdy] = i;
        nrdy++;
        rdy_since++;
      end
      if (rsp_valid != '0) begin
        if (rdy_since != 1) multi++;
        rdy_since = 0;
        for (int i = 0; i < N; i++) if (rsp_valid[i]) rsp_ord[nrsp] = i;
        rsp_val[nrsp] = int'(rsp_pp);
        nrsp++;
      end
    end
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (rsp_ord[k] !== exp_id[k] || rsp_val[k] !== exp_pp[k] || rdy_ord[k] !== exp_id[k]) begin
        errors++; $display("FAIL b2b_op%0d: got ready=%0d rsp=%0d pp=%0d expected %0d/%0d/%0d",
                           k, rdy_ord[k], rsp_ord[k], rsp_val[k], exp_id[k], exp_id[k], exp_pp[k]); end
    end
    checks++; if (nrdy !== 5 || not_onehot !== 0 || multi !== 0) begin
      errors++; $display("FAIL b2b_ready_count: got readies=%0d non_onehot=%0d bad_ops=%0d expected 5/0/0", nrdy, not_onehot, multi); end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got busy=%0b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_req2_max();
    test_timeout();
    test_reset_mid_wait();
    test_withdraw();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
